// File: rtl/spi_slave.sv
// SPI target, all four CPOL/CPHA modes, oversampled from the system clock.
// Single-entry tx holding register feeds the shift register; rx bytes come out with a 1-cycle strobe.
module spi_slave #(
  parameter int                    DATA_WIDTH  = 8,
  parameter int                    SYNC_STAGES = 2,
  parameter logic [DATA_WIDTH-1:0] IDLE_BYTE   = 8'hFF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cpol,
  input  logic                  cpha,
  input  logic                  sclk,
  input  logic                  ss_b,
  input  logic                  mosi,
  output logic                  miso,
  output logic                  miso_en,
  input  logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  tx_load,
  output logic                  tx_ready,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_valid,
  output logic                  busy,
  output logic                  tx_underrun
);

  localparam int CW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(DATA_WIDTH - 1);

  localparam logic [0:0] IDLE   = 1'b0;
  localparam logic [0:0] ACTIVE = 1'b1;

  logic [SYNC_STAGES-1:0] sclk_sync, ss_sync, mosi_sync;
  logic                   sclk_s, ss_s, mosi_s, sclk_d;

  logic [0:0]            state;
  logic [CW-1:0]         cnt;
  logic [DATA_WIDTH-1:0] tx_sh, rx_sh, hold;
  logic                  hold_full, fresh;

  logic active, start, stop, lead, trail, sample, shift_edge, reload, shift;

  assign sclk_s = sclk_sync[SYNC_STAGES-1];
  assign ss_s   = ss_sync[SYNC_STAGES-1];
  assign mosi_s = mosi_sync[SYNC_STAGES-1];

  always_ff @(posedge clk) begin
    if (!rst) begin
      sclk_sync <= {SYNC_STAGES{cpol}};
      ss_sync   <= '1;
      mosi_sync <= '0;
      sclk_d    <= cpol;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
      ss_sync   <= {ss_sync[SYNC_STAGES-2:0], ss_b};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
      sclk_d    <= sclk_s;
    end
  end

  always_comb begin
    active     = (state == ACTIVE) && !ss_s;
    start      = (state == IDLE) && !ss_s;
    stop       = (state == ACTIVE) && ss_s;
    lead       = active && (sclk_s != sclk_d) && (sclk_s != cpol);
    trail      = active && (sclk_s != sclk_d) && (sclk_s == cpol);
    sample     = cpha ? trail : lead;
    shift_edge = cpha ? lead : trail;
    // cnt==0 on a shift edge means a byte boundary; in cpha=1 the very first
    // leading edge of the frame uses the byte loaded at frame start.
    reload     = start || (shift_edge && (cnt == '0) && !(cpha && fresh));
    shift      = shift_edge && !reload && !(cpha && (cnt == '0));
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= IDLE;
      cnt         <= '0;
      tx_sh       <= '0;
      rx_sh       <= '0;
      hold        <= '0;
      hold_full   <= 1'b0;
      fresh       <= 1'b0;
      rx_data     <= '0;
      rx_valid    <= 1'b0;
      tx_underrun <= 1'b0;
    end else begin
      rx_valid    <= 1'b0;
      tx_underrun <= 1'b0;

      if (start)     state <= ACTIVE;
      else if (stop) state <= IDLE;

      if (start || stop)
        cnt <= '0;
      else if (sample)
        cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;

      if (sample) begin
        rx_sh <= {rx_sh[DATA_WIDTH-2:0], mosi_s};
        if (cnt == LAST) begin
          rx_data  <= {rx_sh[DATA_WIDTH-2:0], mosi_s};
          rx_valid <= 1'b1;
        end
      end

      if (start)     fresh <= 1'b1;
      else if (lead) fresh <= 1'b0;

      if (reload) begin
        tx_sh       <= hold_full ? hold : IDLE_BYTE;
        tx_underrun <= !hold_full;
      end else if (shift) begin
        tx_sh <= {tx_sh[DATA_WIDTH-2:0], 1'b0};
      end

      // A transfer only happens while full, so a same-cycle load is never accepted.
      if (reload && hold_full) begin
        hold_full <= 1'b0;
      end else if (tx_load && !hold_full) begin
        hold      <= tx_data;
        hold_full <= 1'b1;
      end
    end
  end

  assign miso     = (state == ACTIVE) ? tx_sh[DATA_WIDTH-1] : 1'b0;
  assign miso_en  = (state == ACTIVE);
  assign busy     = (state == ACTIVE);
  assign tx_ready = !hold_full;

endmodule

// File: tb/tb_spi_slave.sv
// Directed bench for spi_slave: an SPI master model drives frames in all modes
// and immediate assertions compare against hand-computed values.
module tb_spi_slave;
  localparam int H = 6;

  logic       clk = 1'b0, rst = 1'b0, cpol = 1'b0, cpha = 1'b0;
  logic       sclk = 1'b0, ss_b = 1'b1, mosi = 1'b0, tx_load = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       miso, miso_en, tx_ready, rx_valid, busy, tx_underrun;
  logic [7:0] rx_data;

  int checks = 0, errors = 0;
  int vcnt = 0, ucnt = 0;
  logic [7:0] rx_log [0:15];

  spi_slave #(.DATA_WIDTH(8), .SYNC_STAGES(2), .IDLE_BYTE(8'hFF)) dut (
    .clk(clk), .rst(rst), .cpol(cpol), .cpha(cpha), .sclk(sclk), .ss_b(ss_b),
    .mosi(mosi), .miso(miso), .miso_en(miso_en), .tx_data(tx_data),
    .tx_load(tx_load), .tx_ready(tx_ready), .rx_data(rx_data),
    .rx_valid(rx_valid), .busy(busy), .tx_underrun(tx_underrun)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rx_valid) begin
      if (vcnt < 16) rx_log[vcnt] = rx_data;
      vcnt++;
    end
    if (tx_underrun) ucnt++;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_mode(input logic p, input logic h);
    cpol = p; cpha = h; sclk = p;
    tick(8);
  endtask

  task automatic load(input logic [7:0] d);
    int k;
    k = 0;
    while (!tx_ready && k < 50) begin tick(1); k++; end
    chk("load_ready", tx_ready, 1);
    tx_data = d; tx_load = 1'b1;
    tick(1);
    tx_load = 1'b0;
  endtask

  task automatic frame_start();
    ss_b = 1'b0;
    tick(H);
  endtask

  task automatic frame_end();
    tick(H);
    ss_b = 1'b1;
    tick(8);
  endtask

  task automatic xbyte(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
    rx = 8'h00;
    for (int i = 7; i > 7 - nbits; i--) begin
      if (!cpha) begin
        mosi = tx[i]; tick(H);
        sclk = ~cpol; rx[i] = miso; tick(H);
        sclk = cpol;
      end else begin
        sclk = ~cpol; mosi = tx[i]; tick(H);
        sclk = cpol; rx[i] = miso; tick(H);
      end
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_miso"}, miso, 0);
    chk({tag, "_miso_en"}, miso_en, 0);
    chk({tag, "_tx_ready"}, tx_ready, 1);
    chk({tag, "_rx_data"}, rx_data, 0);
    chk({tag, "_rx_valid"}, rx_valid, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_underrun"}, tx_underrun, 0);
  endtask

  initial begin
    logic [7:0] r, r1, r2;
    logic [1:0] md [0:2];
    int b, u;
    md[0] = 2'b11; md[1] = 2'b01; md[2] = 2'b10;

    tick(3);
    chk_reset_outputs("por");
    rst = 1'b1;
    tick(2);

    // mode 0: master sends A5, slave returns 3C
    set_mode(1'b0, 1'b0);
    load(8'h3C);
    b = vcnt;
    frame_start();
    chk("m0_ready_after_ss", tx_ready, 1);
    chk("m0_busy", busy, 1);
    chk("m0_miso_en", miso_en, 1);
    xbyte(8'hA5, 8, r);
    frame_end();
    chk("m0_rx_data", rx_data, 8'hA5);
    chk("m0_rx_pulses", vcnt - b, 1);
    chk("m0_miso_bits", r, 8'h3C);

    // modes 3, 1, 2: master sends 5A, slave returns 81
    for (int m = 0; m < 3; m++) begin
      set_mode(md[m][1], md[m][0]);
      load(8'h81);
      b = vcnt;
      frame_start();
      xbyte(8'h5A, 8, r);
      frame_end();
      chk($sformatf("mode%0d_rx_data", md[m]), rx_data, 8'h5A);
      chk($sformatf("mode%0d_master_rx", md[m]), r, 8'h81);
      chk($sformatf("mode%0d_rx_pulses", md[m]), vcnt - b, 1);
    end

    // two bytes in one frame, second tx byte loaded after the frame-start reload
    set_mode(1'b1, 1'b1);
    load(8'h96);
    b = vcnt; u = ucnt;
    frame_start();
    load(8'hC3);
    xbyte(8'h12, 8, r1);
    xbyte(8'h34, 8, r2);
    frame_end();
    chk("two_rx_pulses", vcnt - b, 2);
    chk("two_rx_first", rx_log[b], 8'h12);
    chk("two_rx_second", rx_log[b+1], 8'h34);
    chk("two_master_first", r1, 8'h96);
    chk("two_master_second", r2, 8'hC3);
    chk("two_no_underrun", ucnt - u, 0);

    // empty holding register at frame start
    b = vcnt; u = ucnt;
    frame_start();
    xbyte(8'h66, 8, r);
    frame_end();
    chk("ur_pulses", ucnt - u, 1);
    chk("ur_master_rx", r, 8'hFF);
    chk("ur_rx_data", rx_data, 8'h66);
    chk("ur_rx_pulses", vcnt - b, 1);

    // aborted frame after 3 bits
    set_mode(1'b0, 1'b0);
    b = vcnt;
    frame_start();
    xbyte(8'hF0, 3, r);
    frame_end();
    chk("abort_no_valid", vcnt - b, 0);
    chk("abort_rx_kept", rx_data, 8'h66);
    chk("abort_busy", busy, 0);
    chk("abort_miso_en", miso_en, 0);
    b = vcnt;
    frame_start();
    xbyte(8'h0F, 8, r);
    frame_end();
    chk("after_abort_rx", rx_data, 8'h0F);
    chk("after_abort_pulses", vcnt - b, 1);

    // reset mid-byte with a byte pending in the holding register
    frame_start();
    load(8'h55);
    chk("pre_rst_not_ready", tx_ready, 0);
    xbyte(8'hA5, 4, r);
    rst = 1'b0;
    tick(1);
    chk_reset_outputs("midrst");
    ss_b = 1'b1; sclk = 1'b0; mosi = 1'b0;
    tick(3);
    rst = 1'b1;
    tick(3);
    b = vcnt;
    frame_start();
    xbyte(8'hA5, 8, r);
    frame_end();
    chk("post_rst_rx", rx_data, 8'hA5);
    chk("post_rst_pulses", vcnt - b, 1);
    chk("post_rst_master_rx", r, 8'hFF);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
